// File: rtl/serial_adder_20.sv
// Digit-serial two's-complement adder: Sum = A + B + Cin, LSB digit first,
// with a start/busy/done handshake. One DIGIT-bit slice is added per clock.
module serial_adder_20 #(
  parameter int unsigned WIDTH = 20,
  parameter int unsigned DIGIT = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             Cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] Sum,
  output logic             Cout,
  output logic             Ovf
);

  localparam int unsigned NDIG  = WIDTH / DIGIT;
  localparam int unsigned CNT_W = (NDIG > 1) ? $clog2(NDIG) : 1;
  localparam int unsigned SW    = DIGIT + 1;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d;
  logic [WIDTH-1:0] psum_q, psum_d, sum_q, sum_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             carry_q, carry_d;
  logic             cout_q, cout_d, ovf_q, ovf_d;
  logic             busy_q, busy_d, done_q, done_d;

  logic [SW-1:0]    slice;
  logic             last_dig;
  logic             carry_into_msb;

  // Digit slice adder; carry into the slice MSB is recovered from its sum bit.
  assign slice          = SW'(a_q[DIGIT-1:0]) + SW'(b_q[DIGIT-1:0]) + SW'(carry_q);
  assign last_dig       = (cnt_q == CNT_W'(NDIG - 1));
  assign carry_into_msb = slice[DIGIT-1] ^ a_q[DIGIT-1] ^ b_q[DIGIT-1];

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    psum_d  = psum_q;
    cnt_d   = cnt_q;
    carry_d = carry_q;
    sum_d   = sum_q;
    cout_d  = cout_q;
    ovf_d   = ovf_q;
    case (state_q)
      IDLE, DONE: begin
        if (start) begin
          state_d = RUN;
          a_d     = A;
          b_d     = B;
          carry_d = Cin;
          cnt_d   = '0;
          psum_d  = '0;
        end else begin
          state_d = IDLE;
        end
      end
      RUN: begin
        a_d     = a_q >> DIGIT;
        b_d     = b_q >> DIGIT;
        carry_d = slice[DIGIT];
        psum_d  = {slice[DIGIT-1:0], psum_q[WIDTH-1:DIGIT]};
        cnt_d   = cnt_q + 1'b1;
        // Final digit: publish the completed sum directly, never a partial one.
        if (last_dig) begin
          state_d = DONE;
          sum_d   = {slice[DIGIT-1:0], psum_q[WIDTH-1:DIGIT]};
          cout_d  = slice[DIGIT];
          ovf_d   = carry_into_msb ^ slice[DIGIT];
        end
      end
      default: state_d = IDLE;
    endcase
    busy_d = (state_d == RUN);
    done_d = (state_d == DONE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      psum_q  <= '0;
      cnt_q   <= '0;
      carry_q <= 1'b0;
      sum_q   <= '0;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      psum_q  <= psum_d;
      cnt_q   <= cnt_d;
      carry_q <= carry_d;
      sum_q   <= sum_d;
      cout_q  <= cout_d;
      ovf_q   <= ovf_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign busy = busy_q;
  assign done = done_q;
  assign Sum  = sum_q;
  assign Cout = cout_q;
  assign Ovf  = ovf_q;

endmodule
